// File: rtl/display_hex_mux_pkg.sv
// Shared segment type, blank pattern and hex-to-segment decode for the display driver.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    // Segment order a..g with a in bit 6; a 0 lights the segment.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_hex_mux_if.sv
// Bundle between user logic (value/load/digit_en) and the display pins (seven/anodo/frame_done).
interface display_hex_mux_if #(
    parameter int N_DIGITS = 4
);
    import display_pkg::*;

    // load is a single-cycle strobe with no back-pressure: value is captured on every
    // clock edge where load=1, the last one before a frame start wins.
    logic [4*N_DIGITS-1:0] value;
    logic                  load;
    logic [N_DIGITS-1:0]   digit_en;
    seg_t                  seven;
    logic [N_DIGITS-1:0]   anodo;
    logic                  frame_done;

    modport master (
        output value, load, digit_en,
        input  seven, anodo, frame_done
    );

    modport slave (
        input  value, load, digit_en,
        output seven, anodo, frame_done
    );

endinterface

// File: rtl/display_hex_mux_dec.sv
// Combinational nibble to active-low 7-segment pattern.
module display_hex_dec
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = hex_to_seg(nib_i);
    end

endmodule

// File: rtl/display_hex_mux.sv
// Time-multiplexed N-digit hex driver for common-anode displays, tear-free frame updates.
// Optional leading-zero blanking when DISPLAY_LZB_EN is defined.
module display_hex_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 27000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    display_hex_mux_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    pend_q, pend_d;
    logic [VAL_W-1:0]    disp_q, disp_d;
    seg_t                seven_q, seven_d;
    logic [N_DIGITS-1:0] anodo_q, anodo_d;
    logic                fd_q, fd_d;

    logic                cnt_wrap;
    logic                frame_wrap;
    logic [3:0]          nib;
    logic                en_cur;
    logic                lz_cur;
    logic                lit;
    logic [N_DIGITS-1:0] lz_mask;
    seg_t                seg_dec;

    always_comb begin
        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (idx_q == IDX_LAST);

        cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        pend_d = bus.load ? bus.value : pend_q;
        // disp only changes at frame start, so a frame never mixes two values.
        disp_d = frame_wrap ? pend_q : disp_q;
        fd_d   = frame_wrap;
    end

`ifdef DISPLAY_LZB_EN
    // A digit is leading-zero if it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_mask    = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = upper_zero && (k != 0);
        end
    end
`else
    always_comb begin
        lz_mask = '0;
    end
`endif

    always_comb begin
        nib    = '0;
        en_cur = 1'b0;
        lz_cur = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib    = disp_q[4*k +: 4];
                en_cur = bus.digit_en[k];
                lz_cur = lz_mask[k];
            end
        end
    end

    display_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (seg_dec)
    );

    // The first BLANK_CYCLES of each slot keep all anodes off to hide ghosting.
    always_comb begin
        lit     = (cnt_q >= CNT_BLANK) && en_cur && !lz_cur;
        seven_d = lit ? seg_dec : SEG_OFF;
        anodo_d = lit ? ~(N_DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            seven_q <= SEG_OFF;
            anodo_q <= '1;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            seven_q <= seven_d;
            anodo_q <= anodo_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.seven      = seven_q;
    assign bus.anodo      = anodo_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_hex_mux.sv
// Frame-level bench for display_hex_mux with N_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
module tb_display_hex_mux;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    display_hex_mux_if #(.N_DIGITS(N)) bus ();

    display_hex_mux #(
        .N_DIGITS     (N),
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DISPLAY_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // One record per 16-cycle frame window: value expected on screen, enables, up to two loads.
    typedef struct {
        logic [15:0] show;
        logic [3:0]  en;
        int          len;
        int          la1;
        logic [15:0] lv1;
        int          la2;
        logic [15:0] lv2;
    } frame_t;

    frame_t      tbl [11];
    frame_t      post;
    logic [6:0]  seg_ref [16];
    logic [11:0] exp_q [$];
    int          n_tests;
    int          n_fail;

    assert property (@(negedge clk) $onehot0(~bus.anodo));

    // Word layout: {frame_done, anodo[3:0], seven[6:0]}; p = cycle within the window.
    function automatic logic [11:0] exp_word(input logic [15:0] show, input logic [3:0] en, input int p);
        int          slot;
        int          pos;
        logic        fd;
        logic        blank;
        logic [15:0] upper;
        logic [3:0]  an;
        slot  = p / 4;
        pos   = p % 4;
        fd    = (p == 15);
        upper = show >> (4 * slot);
        blank = (pos == 0) || !en[slot] || (LZB && (slot != 0) && (upper == 16'h0000));
        an    = ~(4'b0001 << slot);
        if (blank) return {fd, 4'hF, 7'h7F};
        return {fd, an, seg_ref[upper[3:0]]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {bus.frame_done, bus.anodo, bus.seven};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got fd=%b an=%b seg=%b, expected fd=%b an=%b seg=%b",
                     name, act[11], act[10:7], act[6:0], exp[11], exp[10:7], exp[6:0]);
        end
        n_tests++;
        if (!$onehot0(~bus.anodo)) begin
            n_fail++;
            $display("FAIL %s onehot: got an=%b, expected at most one low bit", name, bus.anodo);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 4'hF, 7'h7F});
            step();
            check($sformatf("reset c%0d", i), exp_q.pop_front());
        end
        rst_n    = 1'b1;
        bus.load = 1'b0;
    endtask

    task automatic run_window(input frame_t f, input string tag);
        bus.digit_en = f.en;
        for (int p = 0; p < f.len; p++) begin
            exp_q.push_back(exp_word(f.show, f.en, p));
            step();
            check($sformatf("%s p%0d", tag, p), exp_q.pop_front());
            bus.load = 1'b0;
            if (p == f.la1) begin
                bus.load  = 1'b1;
                bus.value = f.lv1;
            end
            if (p == f.la2) begin
                bus.load  = 1'b1;
                bus.value = f.lv2;
            end
        end
    endtask

    initial begin
        seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        // Load at p=14 is sampled on the frame-wrap edge (coincident case).
        tbl[0]  = '{16'h0000, 4'hF, 16,  0, 16'h1234, -1, 16'h0000};
        tbl[1]  = '{16'h1234, 4'hF, 16, -1, 16'h0000, -1, 16'h0000};
        tbl[2]  = '{16'h1234, 4'hF, 16,  9, 16'hABCD, -1, 16'h0000};
        tbl[3]  = '{16'hABCD, 4'hF, 16,  5, 16'h0F0F, -1, 16'h0000};
        tbl[4]  = '{16'h0F0F, 4'hF, 16,  3, 16'h5678, 14, 16'h9ABC};
        tbl[5]  = '{16'h5678, 4'hF, 16, 14, 16'h8888, -1, 16'h0000};
        tbl[6]  = '{16'h9ABC, 4'hF, 16, 14, 16'h00EF, -1, 16'h0000};
        tbl[7]  = '{16'h8888, 4'b0101, 16, -1, 16'h0000, -1, 16'h0000};
        tbl[8]  = '{16'h00EF, 4'hF, 16,  4, 16'h2222, 10, 16'h0000};
        tbl[9]  = '{16'h0000, 4'hF, 16,  0, 16'h1234, -1, 16'h0000};
        tbl[10] = '{16'h1234, 4'hF,  7,  3, 16'hBEEF, -1, 16'h0000};
        post    = '{16'h0000, 4'hF, 16, -1, 16'h0000, -1, 16'h0000};

        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.digit_en = 4'hF;

        do_reset(3);
        for (int i = 0; i < 11; i++) begin
            run_window(tbl[i], $sformatf("frame%0d", i));
        end

        // Mid-frame reset with BEEF pending and a load held high through reset: both discarded.
        bus.load  = 1'b1;
        bus.value = 16'hFFFF;
        do_reset(2);
        run_window(post, "post_rst0");
        run_window(post, "post_rst1");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        n_tests++;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
